dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: bus cycles allowed in REQ before a forced error completion (only with DMEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 core_ce_i  input  1  core data access request (from core data_ce_o).
REQ-005 core_we_i  input  1  1 = store, 0 = load.
REQ-006 core_addr_i  input  32  byte address from core ALU result.
REQ-007 core_wdata_i  input  32  store data.
REQ-008 core_rdata_o  output  32  load data to core write-back mux.
REQ-009 stall_o  output  1  core must hold PC and all inputs while high.
REQ-010 err_o  output  1  one-cycle pulse: access failed (misaligned, bus error, timeout).
REQ-011 bus_req_o  output  1  bus request, held until bus_ack_i.
REQ-012 bus_we_o  output  1  bus write enable.
REQ-013 bus_addr_o  output  32  word-aligned bus address.
REQ-014 bus_wdata_o  output  32  bus write data.
REQ-015 bus_ack_i  input  1  single-cycle bus completion strobe.
REQ-016 bus_err_i  input  1  bus error; sampled only with bus_ack_i.
REQ-017 bus_rdata_i  input  32  read data; valid with bus_ack_i.

Function
REQ-018 FSM states IDLE, REQ, DONE; IDLE on reset.
REQ-019 IDLE, core_ce_i=1, core_addr_i[1:0]=00: capture we/addr/wdata into registers; next state REQ.
REQ-020 IDLE, core_ce_i=1, core_addr_i[1:0]!=00: no bus request; next state DONE with err flagged.
REQ-021 stall_o combinational = (IDLE & core_ce_i) | REQ; low in DONE.
REQ-022 REQ: bus_req_o=1; bus_we_o/bus_addr_o/bus_wdata_o driven from capture registers, stable until ack.
REQ-023 REQ, bus_ack_i=1: next state DONE; on load without bus_err_i, core_rdata_o <= bus_rdata_i; bus_err_i=1 flags err, core_rdata_o <= 0.
REQ-024 DONE: err_o=1 for exactly this cycle if flagged; next state IDLE unconditionally.
REQ-025 Stores and failed/misaligned accesses never update core_rdata_o except REQ-023 error zeroing; otherwise it holds.
REQ-026 Minimum latency: ce in cycle N, bus_req_o in N+1, ack in N+1 -> DONE in N+2, stall_o low in N+2.
REQ-027 bus_ack_i in IDLE or DONE ignored; bus_req_o never high outside REQ.

Reset
REQ-028 On rst: state IDLE, bus_req_o=0, err_o=0, core_rdata_o=0, capture registers 0, timeout counter 0.
REQ-029 rst during REQ aborts the access; bus_req_o low from next cycle; late ack ignored.

Configuration
REQ-030 Macro DMEM_TIMEOUT_EN defined: counter increments each REQ cycle without ack; at TIMEOUT_CYC, drop bus_req_o, go DONE, flag err, core_rdata_o unchanged; counter clears on entering REQ.
REQ-031 Macro undefined: no counter logic; REQ waits for bus_ack_i indefinitely.
REQ-032 Ack and timeout in same cycle: ack wins.

Structure
REQ-033 Package dmem_bus_pkg holds the state enum, TIMEOUT_CYC default, and 32-bit width constants.
REQ-034 One sub-module dmem_timeout (counter + expiry flag), instantiated only under DMEM_TIMEOUT_EN.

Verification
REQ-035 Load 0x0000_0010, ack after 3 cycles with 0xDEAD_BEEF -> stall_o 4 cycles, core_rdata_o=0xDEADBEEF, err_o=0.
REQ-036 Store 0x0000_0020 data 0x1234_5678, immediate ack -> bus_we_o=1, bus_wdata_o=0x12345678, stall 2 cycles, core_rdata_o unchanged.
REQ-037 Load 0x0000_0013 -> bus_req_o never high, err_o pulse next cycle, stall 1 cycle.
REQ-038 Load, ack with bus_err_i=1 -> err_o pulse, core_rdata_o=0.
REQ-039 DMEM_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> bus_req_o low after 16 REQ cycles, err_o pulse; without macro stall_o stays high.
REQ-040 rst asserted mid-REQ, ack one cycle later -> IDLE, bus_req_o 0, ack ignored, outputs at reset values.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// ============================================================================
// Module      : dmem_bus_pkg
// Description : Shared types and constants for the data-memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_bus_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bus_if.sv
// ============================================================================
// Module      : dmem_bus_if
// Description : Word-wide request/acknowledge bus between bridge and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dmem_bus_if;
    import dmem_bus_pkg::*;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic              bus_err_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_wdata_o,
        input  bus_ack_i,
        input  bus_err_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        output bus_ack_i,
        output bus_err_i,
        output bus_rdata_i
    );

endinterface

`default_nettype wire

// File: rtl/dmem_timeout.sv
// ============================================================================
// Module      : dmem_timeout
// Description : Counts unacknowledged request cycles and flags expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  in_req_i,
    input  wire  ack_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is raised during the last permitted request cycle; an ack in that
    // same cycle takes priority.
    assign expired_o = in_req_i && !ack_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (!in_req_i) begin
            cnt_d = '0;
        end else if (!ack_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ============================================================================
// Module      : dmem_bridge
// Description : Core data port to single-outstanding request/ack bus bridge.
//               Optional request timeout enabled by macro DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_bridge
    import dmem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               core_ce_i,
    input  wire               core_we_i,
    input  wire  [ADDR_W-1:0] core_addr_i,
    input  wire  [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              stall_o,
    output logic              err_o,
    dmem_bus_if.master        bus
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYC must be at least 1");
    end

    state_e            state_q,  state_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              err_q,    err_d;
    logic              timeout_w;

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .in_req_i  (state_q == ST_REQ),
        .ack_i     (bus.bus_ack_i),
        .expired_o (timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (core_ce_i) begin
                    if (word_aligned(core_addr_i[1:0])) begin
                        we_d    = core_we_i;
                        addr_d  = {core_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d = core_wdata_i;
                        state_d = ST_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_ack_i) begin
                    state_d = ST_DONE;
                    if (bus.bus_err_i) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!we_q) begin
                        rdata_d = bus.bus_rdata_i;
                    end
                end else if (timeout_w) begin
                    // Abandoned access: read data keeps its previous value.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // err_q is only ever set on entry to DONE, which lasts exactly one cycle.
    assign err_o            = err_q;
    assign core_rdata_o     = rdata_q;
    assign stall_o          = ((state_q == ST_IDLE) && core_ce_i) || (state_q == ST_REQ);
    assign bus.bus_req_o    = (state_q == ST_REQ);
    assign bus.bus_we_o     = we_q;
    assign bus.bus_addr_o   = addr_q;
    assign bus.bus_wdata_o  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// ============================================================================
// Module      : tb_dmem_bridge
// Description : Self-checking bench for dmem_bridge (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_bridge;

    localparam int TO = 16;
`ifdef DMEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_ce;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        stall;
    logic        err;

    dmem_bus_if bus ();

    dmem_bridge #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ce_i    (core_ce),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rdata_o (core_rdata),
        .stall_o      (stall),
        .err_o        (err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rdata_model;

    typedef struct {
        int          stalls;
        int          reqs;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    // Expected outcome of one access from the bridge's externally visible rules.
    function automatic exp_t model(input logic we, input logic [31:0] addr, input int d,
                                   input logic berr, input logic [31:0] brd,
                                   input logic [31:0] prev);
        exp_t e;
        if (addr[1:0] != 2'b00) begin
            e.stalls = 1; e.reqs = 0; e.err = 1'b1; e.rdata = prev;
        end else if (TO_EN && (d == 0 || d > TO)) begin
            e.stalls = TO + 1; e.reqs = TO; e.err = 1'b1; e.rdata = prev;
        end else begin
            e.stalls = d + 1; e.reqs = d; e.err = berr;
            e.rdata  = berr ? 32'h0 : (we ? prev : brd);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; core_ce = 1'b0;
        bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rdata_model = 32'h0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int d, input logic berr, input logic [31:0] brd,
                           input string tag);
        exp_t e;
        int   stalls = 0, reqs = 0, errs = 0, cyc = 0;
        bit   done = 1'b0, bus_ok = 1'b1;
        e = model(we, addr, d, berr, brd, rdata_model);
        @(negedge clk);
        core_ce = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        bus.bus_ack_i = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (stall) stalls++;
            if (err) errs++;
            if (bus.bus_req_o) begin
                reqs++;
                if (bus.bus_we_o !== we || bus.bus_addr_o !== {addr[31:2], 2'b00} ||
                    (we && bus.bus_wdata_o !== wdata))
                    bus_ok = 1'b0;
            end
            if (!stall) begin
                done = 1'b1;
                check({tag, " err_at_done"}, {31'h0, err}, {31'h0, e.err});
                check({tag, " rdata"}, core_rdata, e.rdata);
                core_ce = 1'b0;
            end
            if (bus.bus_req_o && reqs == d) begin
                bus.bus_ack_i = 1'b1; bus.bus_err_i = berr; bus.bus_rdata_i = brd;
            end else begin
                bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0; bus.bus_rdata_i = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        check({tag, " err_after"}, {31'h0, err}, 32'h0);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(e.stalls));
        check({tag, " req_cycles"}, 32'(reqs), 32'(e.reqs));
        check({tag, " err_pulses"}, 32'(errs), 32'(e.err));
        check({tag, " bus_fields"}, {31'h0, bus_ok}, 32'h1);
        rdata_model = e.rdata;
        if (!done) do_reset();
    endtask

    initial begin
        rst = 1'b1; core_ce = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        bus.bus_ack_i = 1'b0; bus.bus_err_i = 1'b0; bus.bus_rdata_i = '0;
        rdata_model = 32'h0;
        do_reset();

        #1;
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset bus_req", {31'h0, bus.bus_req_o}, 32'h0);
        check("reset err", {31'h0, err}, 32'h0);
        check("reset rdata", core_rdata, 32'h0);
        check("reset bus_addr", bus.bus_addr_o, 32'h0);

        run_txn(1'b0, 32'h0000_0010, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, "load_ack3");
        run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0, 32'h5555_AAAA, "store_ack1");
        run_txn(1'b0, 32'h0000_0013, 32'h0, 1, 1'b0, 32'h1111_1111, "misaligned");
        run_txn(1'b0, 32'h0000_0030, 32'h0, 2, 1'b1, 32'h7777_7777, "load_buserr");
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1, 1'b0, 32'h0BAD_CAFE, "load_restore");
        run_txn(1'b1, 32'h0000_0044, 32'hFFFF_0000, 2, 1'b1, 32'h0, "store_buserr");
        run_txn(1'b0, 32'h0000_0048, 32'h0, TO, 1'b0, 32'hC0DE_0016, "ack_at_limit");

`ifdef DMEM_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0050, 32'h0, 0, 1'b0, 32'h0, "timeout");
`else
        begin
            int high = 0;
            @(negedge clk);
            core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0050;
            bus.bus_ack_i = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (stall && (i == 0 || bus.bus_req_o)) high++;
                @(negedge clk);
            end
            check("noack stall_held", 32'(high), 32'd40);
            do_reset();
        end
`endif

        // Abort an access with reset, then offer a late ack.
        run_txn(1'b0, 32'h0000_0060, 32'h0, 1, 1'b0, 32'h5A5A_A5A5, "pre_abort");
        @(negedge clk);
        core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0064;
        @(negedge clk); #1;
        check("abort req_seen", {31'h0, bus.bus_req_o}, 32'h1);
        @(negedge clk);
        rst = 1'b1; core_ce = 1'b0;
        @(negedge clk); #1;
        check("abort bus_req", {31'h0, bus.bus_req_o}, 32'h0);
        check("abort rdata", core_rdata, 32'h0);
        rst = 1'b0; bus.bus_ack_i = 1'b1; bus.bus_err_i = 1'b0; bus.bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk); #1;
        bus.bus_ack_i = 1'b0;
        check("late_ack bus_req", {31'h0, bus.bus_req_o}, 32'h0);
        check("late_ack err", {31'h0, err}, 32'h0);
        check("late_ack stall", {31'h0, stall}, 32'h0);
        check("late_ack rdata", core_rdata, 32'h0);
        rdata_model = 32'h0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 5)),
                    1'($urandom_range(0, 4) == 0), $urandom, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
